// File: rtl/syn_run_ctrl_pkg.sv
// syn_run_ctrl_pkg: run-control state encodings and counter select codes.
package syn_run_ctrl_pkg;
  typedef enum logic [1:0] {
    RC_ST_PAUSE = 2'b00,
    RC_ST_RUN   = 2'b01,
    RC_ST_STEP  = 2'b10,
    RC_ST_HALT  = 2'b11
  } rc_state_e;
  localparam int RC_NUM_CNT = 8;
  localparam logic [2:0] RC_CNT_CYC = 3'd0;
  localparam logic [2:0] RC_CNT_BR  = 3'd1;
  localparam logic [2:0] RC_CNT_TKN = 3'd2;
  localparam logic [2:0] RC_CNT_JMP = 3'd3;
  localparam logic [2:0] RC_CNT_LU  = 3'd4;
  localparam logic [2:0] RC_CNT_PRD = 3'd5;
  localparam logic [2:0] RC_CNT_PRS = 3'd6;
  localparam logic [2:0] RC_CNT_BPH = 3'd7;
endpackage

// File: rtl/syn_sat_counter.sv
// syn_sat_counter: saturating up-counter with synchronous clear.
module syn_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/syn_run_ctrl.sv
// syn_run_ctrl: CPU run/pause/step/halt controller with breakpoint and event counters.
module syn_run_ctrl
  import syn_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             pause_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_dbg,
  input  logic             halted,
  input  logic             is_branch,
  input  logic             branched,
  input  logic             jumped,
  input  logic             load_use,
  input  logic             predict,
  input  logic             predict_success,
  input  logic             cnt_clr,
  input  logic [2:0]       cnt_sel,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cnt_data
);
  rc_state_e state_q, state_d;
  logic skip_q, skip_d;
  logic [RC_NUM_CNT-1:0] inc;
  logic [CNT_W-1:0] cnt_val [RC_NUM_CNT];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RC_ST_PAUSE;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end
  // skip masks the breakpoint on the first RUN cycle so resuming at the break address makes progress
  always_comb begin
    bp_hit  = bp_en && state_q == RC_ST_RUN && pc_dbg == bp_addr && !skip_q;
    cpu_en  = (state_q == RC_ST_RUN && !bp_hit) || state_q == RC_ST_STEP;
    state_d = state_q;
    if (halted)                                    state_d = RC_ST_HALT;
    else if (bp_hit)                               state_d = RC_ST_PAUSE;
    else if (state_q == RC_ST_RUN && pause_req)    state_d = RC_ST_PAUSE;
    else if (state_q == RC_ST_PAUSE && step_req)   state_d = RC_ST_STEP;
    else if (state_q == RC_ST_PAUSE && run_req)    state_d = RC_ST_RUN;
    else if (state_q == RC_ST_STEP)                state_d = RC_ST_PAUSE;
    skip_d = (state_q == RC_ST_PAUSE && state_d == RC_ST_RUN) ? 1'b1 :
             (state_q == RC_ST_RUN) ? 1'b0 : skip_q;
    inc = '0;
    inc[RC_CNT_CYC] = cpu_en;
    inc[RC_CNT_BR]  = cpu_en && is_branch;
    inc[RC_CNT_TKN] = cpu_en && branched;
    inc[RC_CNT_JMP] = cpu_en && jumped;
    inc[RC_CNT_LU]  = cpu_en && load_use;
    inc[RC_CNT_PRD] = cpu_en && predict;
    inc[RC_CNT_PRS] = cpu_en && predict_success;
    inc[RC_CNT_BPH] = bp_hit;
  end
  for (genvar g = 0; g < RC_NUM_CNT; g++) begin : g_cnt
    syn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[g]),
      .clr (cnt_clr),
      .cnt (cnt_val[g])
    );
  end
  assign state    = state_q;
  assign cnt_data = cnt_val[cnt_sel];
endmodule

// File: tb/tb_syn_run_ctrl.sv
// tb_syn_run_ctrl: directed and random checks of syn_run_ctrl against a behavioural model.
module tb_syn_run_ctrl;
  localparam int W = 4;
  localparam int SAT = 15;
  logic clk = 0;
  logic rst, run_req, pause_req, step_req, bp_en, halted;
  logic is_branch, branched, jumped, load_use, predict, predict_success, cnt_clr;
  logic [31:0] bp_addr, pc_dbg;
  logic [2:0] cnt_sel;
  logic cpu_en, bp_hit;
  logic [1:0] state;
  logic [W-1:0] cnt_data;
  int total = 0, bad = 0;
  int m_state, m_skip, m_pc;
  int m_cnt [8];

  always #5 clk = ~clk;

  syn_run_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .pause_req(pause_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_dbg(pc_dbg), .halted(halted),
    .is_branch(is_branch), .branched(branched), .jumped(jumped), .load_use(load_use),
    .predict(predict), .predict_success(predict_success), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .cnt_data(cnt_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_bp();
    return bp_en && m_state == 1 && pc_dbg == bp_addr && m_skip == 0;
  endfunction

  // one clock: check outputs against the model, then advance model and DUT together
  task automatic cycle();
    bit bp, en;
    int ns;
    bit f [8];
    #1;
    bp = m_bp();
    en = (m_state == 1 && !bp) || m_state == 2;
    chk("state", 32'(state), m_state);
    chk("cpu_en", 32'(cpu_en), 32'(en));
    chk("bp_hit", 32'(bp_hit), 32'(bp));
    chk("cnt_data", 32'(cnt_data), m_cnt[cnt_sel]);
    if (rst) ns = 0;
    else if (halted) ns = 3;
    else if (bp) ns = 0;
    else if (m_state == 1 && pause_req) ns = 0;
    else if (m_state == 0 && step_req) ns = 2;
    else if (m_state == 0 && run_req) ns = 1;
    else if (m_state == 2) ns = 0;
    else ns = m_state;
    f = '{en, en && is_branch, en && branched, en && jumped, en && load_use,
          en && predict, en && predict_success, bp};
    @(posedge clk);
    for (int i = 0; i < 8; i++)
      m_cnt[i] = (rst || cnt_clr) ? 0 : (f[i] && m_cnt[i] < SAT) ? m_cnt[i] + 1 : m_cnt[i];
    m_skip = rst ? 0 : (m_state == 0 && ns == 1) ? 1 : (m_state == 1) ? 0 : m_skip;
    m_pc = rst ? 0 : en ? (m_pc + 4) & 63 : m_pc;
    m_state = ns;
    @(negedge clk);
    run_req = 0; pause_req = 0; step_req = 0; cnt_clr = 0;
    pc_dbg = m_pc;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; run_req = 0; pause_req = 0; step_req = 0; bp_en = 0; halted = 0;
    is_branch = 0; branched = 0; jumped = 0; load_use = 0; predict = 0; predict_success = 0;
    cnt_clr = 0; bp_addr = 0; pc_dbg = 0; cnt_sel = 0;
    m_state = 0; m_skip = 0; m_pc = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cnt_sel = 3'(i);
      #1 chk("reset_cnt", 32'(cnt_data), 0);
    end
    cnt_sel = 0;
    do_reset();
    chk("reset_state", 32'(state), 0);
    chk("reset_en", 32'(cpu_en), 0);
    // free run, no breakpoint
    run_req = 1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      #1 chk("run_en", 32'(cpu_en), 1);
      cycle();
    end
    chk("run_state", 32'(state), 1);
    chk("run_cyc10", 32'(cnt_data), 10);
    // breakpoint at 0x10, then resume past it
    do_reset();
    bp_en = 1; bp_addr = 32'h10;
    run_req = 1;
    cycle();
    for (int i = 0; i < 20 && !m_bp(); i++) cycle();
    #1 chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_en_low", 32'(cpu_en), 0);
    cycle();
    chk("bp_pause", 32'(state), 0);
    cnt_sel = 7;
    #1 chk("bph1", 32'(cnt_data), 1);
    run_req = 1;
    cycle();
    #1 chk("resume_en", 32'(cpu_en), 1);
    chk("resume_nohit", 32'(bp_hit), 0);
    cycle();
    bp_en = 0;
    // three single steps
    do_reset();
    cnt_sel = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1;
      cycle();
      #1 chk("step_en", 32'(cpu_en), 1);
      chk("step_state", 32'(state), 2);
      cycle();
      chk("step_back", 32'(state), 0);
      cycle();
      cycle();
    end
    chk("step_cyc3", 32'(cnt_data), 3);
    // halt wins over coincident pause_req and breakpoint
    do_reset();
    run_req = 1;
    repeat (3) cycle();
    bp_en = 1; bp_addr = pc_dbg; pause_req = 1; halted = 1;
    #1 chk("halt_bp", 32'(bp_hit), 1);
    cycle();
    halted = 0; bp_en = 0;
    chk("halt_state", 32'(state), 3);
    run_req = 1;
    cycle();
    step_req = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_en", 32'(cpu_en), 0);
      chk("halt_stay", 32'(state), 3);
      cycle();
    end
    do_reset();
    chk("halt_exit", 32'(state), 0);
    // saturation and clear-over-increment
    cnt_sel = 1; is_branch = 1;
    run_req = 1;
    cycle();
    repeat (20) cycle();
    chk("br_sat", 32'(cnt_data), 15);
    cnt_clr = 1;
    cycle();
    #1 chk("br_clr", 32'(cnt_data), 0);
    is_branch = 0;
    // reset mid-run
    do_reset();
    cnt_sel = 0;
    run_req = 1;
    cycle();
    repeat (7) cycle();
    chk("mid_cyc7", 32'(cnt_data), 7);
    rst = 1;
    cycle();
    rst = 0;
    #1 chk("mid_state", 32'(state), 0);
    chk("mid_cyc0", 32'(cnt_data), 0);
    chk("mid_en", 32'(cpu_en), 0);
    // random soak against the model
    for (int n = 0; n < 500; n++) begin
      run_req = $urandom_range(0, 3) == 0;
      pause_req = $urandom_range(0, 6) == 0;
      step_req = $urandom_range(0, 4) == 0;
      halted = $urandom_range(0, 80) == 0;
      rst = $urandom_range(0, 40) == 0;
      cnt_clr = $urandom_range(0, 30) == 0;
      bp_en = 1'($urandom);
      bp_addr = 32'($urandom_range(0, 15) * 4);
      is_branch = 1'($urandom); branched = 1'($urandom); jumped = 1'($urandom);
      load_use = 1'($urandom); predict = 1'($urandom); predict_success = 1'($urandom);
      cnt_sel = 3'($urandom);
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
